// File: rtl/vga_fetch_arbiter.sv
// Ping-pong line buffer feeding the VGA core, filled row by row from a shared framebuffer port also used by a renderer.
// Latency: pixstream 1 cycle after hpos; mem_rdata expected 1 cycle after a read strobe; wr_ready is combinational.
// Backpressure: writer waits while a fetch owns the port (alternating grants when VGA_FETCH_RR_EN is defined).
module vga_fetch_arbiter #(
    parameter int FB_WIDTH       = 160,
    parameter int FB_HEIGHT      = 120,
    parameter int PRESCALE_SHIFT = 2
) (
    input  logic        clk_25_175,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    output logic [11:0] pixstream,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic        underrun
);

    localparam logic [7:0]  FB_W8   = 8'(FB_WIDTH);
    localparam logic [6:0]  FB_H7   = 7'(FB_HEIGHT);
    localparam logic [14:0] FB_W15  = 15'(FB_WIDTH);
    localparam logic [7:0]  LAST_COL = 8'(FB_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [11:0] lb0 [FB_WIDTH];
    logic [11:0] lb1 [FB_WIDTH];
    logic        disp_sel;
    logic [6:0]  fetch_row;
    logic [7:0]  fetch_col;
    logic        rd_pend;
    logic [7:0]  rd_col;
    logic        fetch_gnt, wr_gnt;
    logic        trig, swap, visible, wr_in_range;
    logic [6:0]  trig_row;
    logic [7:0]  disp_col;
    logic [14:0] fetch_addr, wr_addr;

    assign trig = (hpos == 10'd0) &&
                  ((vpos == 10'd524) || ((vpos[1:0] == 2'd0) && (vpos < 10'd476)));
    assign trig_row = (vpos == 10'd524) ? 7'd0 : 7'(vpos >> PRESCALE_SHIFT) + 7'd1;
    assign swap = (hpos == 10'd799) &&
                  (((vpos[1:0] == 2'd3) && (vpos < 10'd479)) || (vpos == 10'd524));
    assign visible  = (hpos < 10'd640) && (vpos < 10'd480);
    assign disp_col = 8'(hpos >> PRESCALE_SHIFT);

    assign wr_in_range = (wr_x < FB_W8) && (wr_y < FB_H7);
    assign fetch_addr  = 15'(fetch_row) * FB_W15 + 15'(fetch_col);
    assign wr_addr     = 15'(wr_y) * FB_W15 + 15'(wr_x);
    assign wr_ready    = wr_gnt;

`ifdef VGA_FETCH_RR_EN
    logic rr_wr_next;

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset)
            rr_wr_next <= 1'b0;
        else if (fetch_gnt)
            rr_wr_next <= 1'b1;
        else if (wr_gnt)
            rr_wr_next <= 1'b0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        fetch_gnt = 1'b0;
        wr_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

`ifdef VGA_FETCH_RR_EN
        if ((state_q == FETCH) && wr_valid) begin
            fetch_gnt = !rr_wr_next;
            wr_gnt    = rr_wr_next && reset;
        end else begin
            fetch_gnt = (state_q == FETCH);
            wr_gnt    = wr_valid && reset;
        end
`else
        fetch_gnt = (state_q == FETCH);
        wr_gnt    = wr_valid && reset && (state_q != FETCH);
`endif

        if (fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end else if (wr_gnt && wr_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end

        case (state_q)
            IDLE:    if (trig) state_d = FETCH;
            FETCH:   if (fetch_gnt && (fetch_col == LAST_COL)) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A swap always wins; an unfinished fetch is thrown away.
        if (swap)
            state_d = IDLE;
    end

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            disp_sel  <= 1'b0;
            underrun  <= 1'b0;
            fetch_row <= '0;
            fetch_col <= '0;
            rd_pend   <= 1'b0;
            rd_col    <= '0;
            pixstream <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && trig) begin
                fetch_row <= trig_row;
                fetch_col <= '0;
            end else if (fetch_gnt) begin
                fetch_col <= fetch_col + 8'd1;
            end
            // Read data returning after a swap belongs to an abandoned row.
            rd_pend <= fetch_gnt && !swap;
            rd_col  <= fetch_col;
            if (swap) begin
                disp_sel <= !disp_sel;
                if (state_q != IDLE)
                    underrun <= 1'b1;
            end
            if (visible)
                pixstream <= disp_sel ? lb1[disp_col] : lb0[disp_col];
            else
                pixstream <= '0;
        end
    end

    always_ff @(posedge clk_25_175) begin
        if (rd_pend) begin
            if (disp_sel)
                lb0[rd_col] <= mem_rdata;
            else
                lb1[rd_col] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter with a 1-cycle-latency framebuffer model.
module tb_vga_fetch_arbiter;

    logic        clk_25_175 = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic [11:0] pixstream;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        underrun;

    logic [11:0] mem [19200];
    logic        preload_req;
    logic        stuck;

    int errors = 0;
    int checks = 0;
    int en_seen, rd_cnt, wr_rdy_cnt, zero_run, max_zero_run;

    always #5 clk_25_175 = !clk_25_175;

    vga_fetch_arbiter dut (
        .clk_25_175 (clk_25_175),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixstream  (pixstream),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .underrun   (underrun)
    );

    always @(posedge clk_25_175) begin
        if (preload_req) begin
            for (int k = 0; k < 120; k++)
                for (int c = 0; c < 160; c++)
                    mem[160*k + c] <= 12'(((k % 16) << 8) | c);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else if (!stuck)
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        en_seen = 0; rd_cnt = 0; wr_rdy_cnt = 0; zero_run = 0; max_zero_run = 0;
    endtask

    // Present hpos h0..h1 on line v, one per cycle; afterwards the last hpos has been clocked in.
    task automatic run_line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            vpos = 10'(v);
            hpos = 10'(h);
            #1;
            if (mem_en) en_seen++;
            if (mem_en && !mem_we) rd_cnt++;
            if (wr_valid) begin
                if (wr_ready) begin
                    wr_rdy_cnt++;
                    zero_run = 0;
                end else begin
                    zero_run++;
                    if (zero_run > max_zero_run) max_zero_run = zero_run;
                end
            end
            @(posedge clk_25_175);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; hpos = '0; vpos = '0; stuck = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        preload_req = 1'b1;
        clear_stats();
        @(posedge clk_25_175);
        #1;
        preload_req = 1'b0;

        // Reset state, with a writer request that must not be granted
        wr_valid = 1'b1;
        #1;
        check("rst_pix", pixstream, 12'h000);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_mem_addr", mem_addr, 15'd0);
        wr_valid = 1'b0;
        @(posedge clk_25_175);
        #1;

        // Release mid-frame: no trigger, so no memory traffic
        vpos = 10'd2; hpos = 10'd100;
        reset = 1'b1;
        clear_stats();
        run_line(2, 100, 799);
        check("no_spurious_en", en_seen, 0);

        // In-range write then out-of-range write, while idle
        vpos = 10'd3; hpos = 10'd0;
        wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd0; wr_data = 12'hABC;
        #1;
        check("wr_ready", wr_ready, 1'b1);
        check("wr_mem_en", mem_en, 1'b1);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_addr", mem_addr, 15'd3);
        check("wr_wdata", mem_wdata, 12'hABC);
        @(posedge clk_25_175);
        #1;
        hpos = 10'd1; wr_x = 8'd200; wr_y = 7'd5; wr_data = 12'h555;
        #1;
        check("drop_ready", wr_ready, 1'b1);
        check("drop_mem_en", mem_en, 1'b0);
        check("drop_addr", mem_addr, 15'd0);
        @(posedge clk_25_175);
        #1;
        wr_valid = 1'b0;
        run_line(3, 2, 799);
        check("swap_idle_underrun", underrun, 1'b0);

        // Frame with row 0 shown on lines 0..3
        run_line(524, 0, 799);
        run_line(0, 0, 11);
        check("pix_v0_h11", pixstream, 12'h002);
        for (int h = 12; h <= 15; h++) begin
            run_line(0, h, h);
            check("pix_written_v0", pixstream, 12'hABC);
        end
        run_line(0, 16, 20);
        check("pix_v0_h20", pixstream, 12'h005);
        run_line(0, 21, 700);
        check("pix_blank", pixstream, 12'h000);
        run_line(0, 701, 799);
        run_line(1, 0, 799);
        run_line(2, 0, 799);
        run_line(3, 0, 15);
        check("pix_written_v3", pixstream, 12'hABC);
        run_line(3, 16, 799);

        // Writer held valid through the fetch of row 2 (writes dropped)
        clear_stats();
        wr_valid = 1'b1; wr_x = 8'd200; wr_y = 7'd5; wr_data = 12'h123;
        run_line(4, 0, 320);
        wr_valid = 1'b0;
`ifdef VGA_FETCH_RR_EN
        check("rr_reads_320", rd_cnt, 160);
        check("rr_alternate", (max_zero_run <= 1) ? 1 : 0, 1);
        check("rr_wr_grants", (wr_rdy_cnt >= 160) ? 1 : 0, 1);
`else
        check("prio_reads", rd_cnt, 160);
        check("prio_stall_run", max_zero_run, 160);
`endif
        run_line(4, 321, 799);
        run_line(5, 0, 799);
        run_line(6, 0, 799);
        run_line(7, 0, 799);
        run_line(8, 0, 20);
        check("pix_v8_h20", pixstream, 12'h205);
        run_line(8, 21, 639);
        check("pix_v8_h639", pixstream, 12'h29F);
        run_line(8, 640, 799);

        // Last framebuffer row at the bottom of the screen
        for (int v = 472; v <= 475; v++)
            run_line(v, 0, 799);
        run_line(479, 0, 639);
        check("pix_v479_h639", pixstream, 12'h79F);
        check("frame_underrun", underrun, 1'b0);
        check("drop_mem_intact", mem[1000], 12'h628);

        // Reset in the middle of a fetch
        run_line(4, 0, 50);
        hpos = 10'd51;
        #1;
        check("midfetch_en", mem_en, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_mem_en", mem_en, 1'b0);
        check("rst_mid_pix", pixstream, 12'h000);
        @(posedge clk_25_175);
        #1;
        reset = 1'b1;
        clear_stats();
        run_line(6, 0, 20);
        check("post_rst_idle", en_seen, 0);

        // Swap during a fetch with read data stuck
        stuck = 1'b1;
        run_line(4, 0, 50);
        run_line(7, 799, 799);
        check("underrun_set", underrun, 1'b1);
        clear_stats();
        run_line(9, 0, 30);
        check("abandon_idle", en_seen, 0);
        run_line(9, 31, 799);
        check("underrun_sticky", underrun, 1'b1);
        reset = 1'b0;
        #1;
        check("underrun_cleared", underrun, 1'b0);
        stuck = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
